// File: rtl/noc_common_pkg.sv
// NoC common definitions shared by the traffic generator and checker:
// payload layout is {timestamp, sequence}, each half of tdata.
package noc_common_pkg;

    localparam int unsigned NOC_MAX_DATA_WIDTH = 128;
    localparam int unsigned NOC_MAX_HALF_WIDTH = NOC_MAX_DATA_WIDTH / 2;

    typedef logic [NOC_MAX_DATA_WIDTH-1:0] noc_data_t;
    typedef logic [NOC_MAX_HALF_WIDTH-1:0] noc_half_t;

    function automatic noc_half_t payload_half_mask(input int unsigned half_width);
        if (half_width >= NOC_MAX_HALF_WIDTH) begin
            return '1;
        end
        return (noc_half_t'(1) << half_width) - noc_half_t'(1);
    endfunction

    // Sequence number: low half of the payload.
    function automatic noc_half_t payload_seq(input noc_data_t data, input int unsigned data_width);
        return noc_half_t'(data) & payload_half_mask(data_width / 2);
    endfunction

    // Injection timestamp: high half of the payload.
    function automatic noc_half_t payload_ts(input noc_data_t data, input int unsigned data_width);
        return noc_half_t'(data >> (data_width / 2)) & payload_half_mask(data_width / 2);
    endfunction

endpackage

// File: rtl/axis_traffic_checker.sv
// AXI-Stream NoC endpoint checker: counts single-flit packets per source and
// raises a sticky error on misrouting, bad framing, sequence gaps or future timestamps.
module axis_traffic_checker
    import noc_common_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 32,
    parameter int unsigned TDEST       = 0,
    parameter int unsigned TDATA_WIDTH = 64,
    parameter int unsigned TDEST_WIDTH = 2,
    parameter int unsigned TID_WIDTH   = 2,
    parameter int unsigned NUM_ROUTERS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [TDATA_WIDTH/2-1:0]   ticks,
    output logic [COUNT_WIDTH-1:0]     recv_packets [NUM_ROUTERS],
    output logic [COUNT_WIDTH-1:0]     total_recv_packets,
    output logic                       error,
    input  logic                       axis_in_tvalid,
    output logic                       axis_in_tready,
    input  logic [TDATA_WIDTH-1:0]     axis_in_tdata,
    input  logic                       axis_in_tlast,
    input  logic [TID_WIDTH-1:0]       axis_in_tid,
    input  logic [TDEST_WIDTH-1:0]     axis_in_tdest
);

    localparam int unsigned HALF_WIDTH = TDATA_WIDTH / 2;

    if ((TDATA_WIDTH % 2) != 0) begin : g_bad_data_width
        $error("axis_traffic_checker: TDATA_WIDTH must be even");
    end
    if (NUM_ROUTERS > (1 << TID_WIDTH)) begin : g_bad_num_routers
        $error("axis_traffic_checker: NUM_ROUTERS exceeds tid range");
    end

    logic                   tready_q;
    logic                   error_q;
    logic                   error_d;
    logic [COUNT_WIDTH-1:0] total_q;
    logic [COUNT_WIDTH-1:0] cnt_q [NUM_ROUTERS];

    logic                   accept;
    logic                   tid_ok;
    logic                   dest_ok;
    logic                   seq_ok;
    logic                   ts_ok;
    logic                   beat_bad;
    logic [COUNT_WIDTH-1:0] sel_cnt;
    logic [HALF_WIDTH-1:0]  seq_w;
    logic [HALF_WIDTH-1:0]  ts_w;

    assign accept = axis_in_tvalid && tready_q;
    assign seq_w  = HALF_WIDTH'(payload_seq(noc_data_t'(axis_in_tdata), TDATA_WIDTH));
    assign ts_w   = HALF_WIDTH'(payload_ts(noc_data_t'(axis_in_tdata), TDATA_WIDTH));

    // Per-beat checks against the counter of the beat's source.
    always_comb begin
        sel_cnt = '0;
        for (int unsigned i = 0; i < NUM_ROUTERS; i++) begin
            if (axis_in_tid == TID_WIDTH'(i)) begin
                sel_cnt = cnt_q[i];
            end
        end
        tid_ok   = 32'(axis_in_tid) < NUM_ROUTERS;
        dest_ok  = axis_in_tdest == TDEST_WIDTH'(TDEST);
        seq_ok   = seq_w == HALF_WIDTH'(sel_cnt);
        ts_ok    = ts_w <= ticks;
        beat_bad = !(tid_ok && dest_ok && seq_ok && ts_ok && axis_in_tlast);
        error_d  = error_q || (accept && beat_bad);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tready_q <= 1'b0;
            error_q  <= 1'b0;
            total_q  <= '0;
        end else begin
            tready_q <= 1'b1;
            error_q  <= error_d;
            if (accept) begin
                total_q <= total_q + COUNT_WIDTH'(1);
            end
        end
    end

    // One counter per source; out-of-range tids match none of them.
    for (genvar g = 0; g < NUM_ROUTERS; g++) begin : g_src_cnt
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q[g] <= '0;
            end else if (accept && (axis_in_tid == TID_WIDTH'(g))) begin
                cnt_q[g] <= cnt_q[g] + COUNT_WIDTH'(1);
            end
        end
        assign recv_packets[g] = cnt_q[g];
    end

    assign total_recv_packets = total_q;
    assign error              = error_q;
    assign axis_in_tready     = tready_q;

endmodule

// File: tb/tb_axis_traffic_checker.sv
// Directed self-checking bench for axis_traffic_checker (default parameters).
module tb_axis_traffic_checker;

    logic        clk;
    logic        rst_n;
    logic [31:0] ticks;
    logic [31:0] recv_packets [4];
    logic [31:0] total_recv_packets;
    logic        error;
    logic        axis_in_tvalid;
    logic        axis_in_tready;
    logic [63:0] axis_in_tdata;
    logic        axis_in_tlast;
    logic [1:0]  axis_in_tid;
    logic [1:0]  axis_in_tdest;

    int total_cnt = 0;
    int bad_cnt   = 0;

    axis_traffic_checker dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ticks              (ticks),
        .recv_packets       (recv_packets),
        .total_recv_packets (total_recv_packets),
        .error              (error),
        .axis_in_tvalid     (axis_in_tvalid),
        .axis_in_tready     (axis_in_tready),
        .axis_in_tdata      (axis_in_tdata),
        .axis_in_tlast      (axis_in_tlast),
        .axis_in_tid        (axis_in_tid),
        .axis_in_tdest      (axis_in_tdest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running global cycle count.
    initial ticks = 32'd100;
    always @(posedge clk) ticks <= ticks + 32'd1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Present one beat for exactly one edge; caller deasserts via idle().
    task automatic send(input logic [1:0] tid, input logic [1:0] dest, input logic [31:0] seq,
                        input logic [31:0] ts, input logic last);
        axis_in_tvalid = 1'b1;
        axis_in_tid    = tid;
        axis_in_tdest  = dest;
        axis_in_tdata  = {ts, seq};
        axis_in_tlast  = last;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        axis_in_tvalid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        axis_in_tvalid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag, input int c0, input int c1, input int c2,
                                input int c3, input int tot, input logic err);
        check({tag, ".cnt0"}, 64'(recv_packets[0]), 64'(c0));
        check({tag, ".cnt1"}, 64'(recv_packets[1]), 64'(c1));
        check({tag, ".cnt2"}, 64'(recv_packets[2]), 64'(c2));
        check({tag, ".cnt3"}, 64'(recv_packets[3]), 64'(c3));
        check({tag, ".total"}, 64'(total_recv_packets), 64'(tot));
        check({tag, ".error"}, 64'(error), 64'(err));
    endtask

    initial begin
        rst_n          = 1'b0;
        axis_in_tvalid = 1'b0;
        axis_in_tdata  = '0;
        axis_in_tlast  = 1'b0;
        axis_in_tid    = '0;
        axis_in_tdest  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst.tready", 64'(axis_in_tready), 64'd0);
        check_counts("rst", 0, 0, 0, 0, 0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst.tready_up", 64'(axis_in_tready), 64'd1);

        // Three in-order packets from source 1
        send(2'd1, 2'd0, 32'd0, ticks, 1'b1);
        send(2'd1, 2'd0, 32'd1, ticks, 1'b1);
        send(2'd1, 2'd0, 32'd2, 32'd0, 1'b1);
        idle(1);
        check_counts("seq3", 0, 3, 0, 0, 3, 1'b0);

        // Quiet cycles change nothing
        idle(3);
        check_counts("quiet", 0, 3, 0, 0, 3, 1'b0);

        // Sequence gap from source 2, error sticks through later valid traffic
        send(2'd2, 2'd0, 32'd0, ticks, 1'b1);
        check("gap.err_before", 64'(error), 64'd0);
        send(2'd2, 2'd0, 32'd2, ticks, 1'b1);
        check("gap.err_after", 64'(error), 64'd1);
        send(2'd1, 2'd0, 32'd3, ticks, 1'b1);
        idle(2);
        check_counts("gap", 0, 4, 2, 0, 6, 1'b1);

        // Mid-stream reset with a beat presented: it must not be counted
        axis_in_tvalid = 1'b1;
        axis_in_tid    = 2'd0;
        axis_in_tdest  = 2'd0;
        axis_in_tdata  = {ticks, 32'd0};
        axis_in_tlast  = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst.tready", 64'(axis_in_tready), 64'd0);
        check_counts("midrst", 0, 0, 0, 0, 0, 1'b0);
        @(posedge clk);
        #1;
        check("midrst.tready_up", 64'(axis_in_tready), 64'd1);
        check("midrst.total_held", 64'(total_recv_packets), 64'd0);
        send(2'd0, 2'd0, 32'd0, ticks, 1'b1);
        idle(1);
        check_counts("postrst", 1, 0, 0, 0, 1, 1'b0);

        // 16 back-to-back beats interleaving sources 0..3
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send(2'(i % 4), 2'd0, 32'(i / 4), ticks, 1'b1);
            check($sformatf("burst.tready%0d", i), 64'(axis_in_tready), 64'd1);
        end
        idle(1);
        check_counts("burst", 4, 4, 4, 4, 16, 1'b0);

        // Wrong destination still counts
        send(2'd0, 2'd3, 32'd4, ticks, 1'b1);
        idle(1);
        check_counts("dest", 5, 4, 4, 4, 17, 1'b1);

        // Timestamp from the future
        do_reset();
        send(2'd0, 2'd0, 32'd0, ticks + 32'd5, 1'b1);
        idle(1);
        check_counts("future", 1, 0, 0, 0, 1, 1'b1);

        // Multi-flit framing
        do_reset();
        send(2'd3, 2'd0, 32'd0, ticks, 1'b0);
        idle(1);
        check_counts("nolast", 0, 0, 0, 1, 1, 1'b1);

        // Duplicate packet
        do_reset();
        send(2'd2, 2'd0, 32'd0, ticks, 1'b1);
        send(2'd2, 2'd0, 32'd0, ticks, 1'b1);
        idle(1);
        check_counts("dup", 0, 0, 2, 0, 2, 1'b1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
